// File: rtl/modmul_unit.sv
// Multi-cycle modular multiplier: MSB-first shift-add, result = (op_a*op_b) mod modulus, written back to the register file.
// Latency: start edge k -> WB cycle after edge k+16; no backpressure, start is ignored while not IDLE.
module modmul_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] modulus,
  input  logic [2:0]  dest_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        reg_write,
  output logic [2:0]  write_addr,
  output logic [15:0] write_data
);

  typedef enum logic [1:0] {IDLE, CALC, WB, ERR} state_t;

  state_t      state;
  logic [15:0] aReg;
  logic [15:0] bReg;
  logic [15:0] nReg;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [2:0]  destReg;

  logic [16:0] dbl;
  logic [16:0] dblRed;
  logic [16:0] sum;
  logic [15:0] nextAcc;

  // acc < n holds every step, so both 17-bit sums fit and one subtract reduces each
  always_comb begin
    dbl     = {acc, 1'b0};
    dblRed  = (dbl >= {1'b0, nReg}) ? dbl - {1'b0, nReg} : dbl;
    sum     = bReg[cnt] ? dblRed + {1'b0, aReg} : dblRed;
    nextAcc = (sum >= {1'b0, nReg}) ? 16'(sum - {1'b0, nReg}) : sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      aReg       <= '0;
      bReg       <= '0;
      nReg       <= '0;
      acc        <= '0;
      cnt        <= '0;
      destReg    <= '0;
      write_data <= '0;
      write_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg    <= op_a;
            bReg    <= op_b;
            nReg    <= modulus;
            destReg <= dest_addr;
            acc     <= '0;
            cnt     <= 4'd15;
            state   <= (modulus == 16'd0 || op_a >= modulus) ? ERR : CALC;
          end
        end
        CALC: begin
          acc <= nextAcc;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state      <= WB;
            write_data <= nextAcc;
            write_addr <= destReg;
          end
        end
        WB:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == CALC) || (state == WB);
  assign done      = (state == WB) || (state == ERR);
  assign err       = (state == ERR);
  assign reg_write = (state == WB);

endmodule

// File: tb/tb_modmul_unit.sv
// Directed plus randomized checks of modmul_unit against an arithmetic (a*b) mod n reference.
module tb_modmul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] modulus;
  logic [2:0]  dest_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic        reg_write;
  logic [2:0]  write_addr;
  logic [15:0] write_data;

  int total = 0;
  int bad   = 0;

  modmul_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .modulus    (modulus),
    .dest_addr  (dest_addr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .reg_write  (reg_write),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] refMod(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return 16'(p % longint'(n));
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n, input logic [2:0] d);
    start = 1'b1; op_a = a; op_b = b; modulus = n; dest_addr = d;
  endtask

  task automatic scramble();
    op_a = 16'($urandom); op_b = 16'($urandom); modulus = 16'($urandom); dest_addr = 3'($urandom);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first IDLE cycle afterwards.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n,
                       input logic [2:0] d, input bit midStart);
    logic [15:0] expData;
    logic [15:0] prevData;
    logic [2:0]  prevAddr;
    prevData = write_data;
    prevAddr = write_addr;
    drive(a, b, n, d);
    @(negedge clk);
    start = 1'b0;
    scramble();
    if (n == 16'd0 || a >= n) begin
      chk("err_pulse", err, 1'b1);
      chk("err_done", done, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_regwrite", reg_write, 1'b0);
      @(negedge clk);
      chk("err_end_err", err, 1'b0);
      chk("err_end_done", done, 1'b0);
      chk("err_end_busy", busy, 1'b0);
      chk("err_end_regwrite", reg_write, 1'b0);
      chk("err_data_hold", write_data, prevData);
      chk("err_addr_hold", write_addr, prevAddr);
    end else begin
      expData = refMod(a, b, n);
      for (int i = 0; i < 16; i++) begin
        chk("calc_busy", busy, 1'b1);
        chk("calc_regwrite", reg_write, 1'b0);
        chk("calc_done", done, 1'b0);
        if (midStart && i == 4) begin
          drive(16'h0003, 16'h0003, 16'h0005, 3'd7);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      chk("wb_regwrite", reg_write, 1'b1);
      chk("wb_done", done, 1'b1);
      chk("wb_busy", busy, 1'b1);
      chk("wb_err", err, 1'b0);
      chk("wb_data", write_data, expData);
      chk("wb_addr", write_addr, d);
      @(negedge clk);
      chk("idle_regwrite", reg_write, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_data_hold", write_data, expData);
      chk("idle_addr_hold", write_addr, d);
    end
  endtask

  initial begin
    logic [15:0] ra, rb, rn;
    rst = 1'b0; start = 1'b0;
    op_a = '0; op_b = '0; modulus = '0; dest_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_regwrite", reg_write, 1'b0);
    chk("rst_data", write_data, 16'h0000);
    chk("rst_addr", write_addr, 3'd0);
    rst = 1'b1;
    @(negedge clk);

    runOp(16'd3, 16'd5, 16'd7, 3'd2, 1'b0);
    runOp(16'hFFFE, 16'hFFFE, 16'hFFFF, 3'd5, 1'b0);
    runOp(16'd1, 16'd1, 16'd0, 3'd1, 1'b0);
    runOp(16'd9, 16'd3, 16'd7, 3'd1, 1'b0);
    runOp(16'd5, 16'h0000, 16'd11, 3'd3, 1'b0);
    runOp(16'd0, 16'hABCD, 16'd1, 3'd4, 1'b0);
    runOp(16'd1234, 16'd4321, 16'd9999, 3'd6, 1'b1);
    runOp(16'hFFFE, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0);
    runOp(16'd7, 16'd2, 16'd7, 3'd0, 1'b0);

    // Reset in the middle of CALC aborts without a write-back.
    drive(16'd100, 16'd200, 16'd301, 3'd6);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_err", err, 1'b0);
      chk("abort_regwrite", reg_write, 1'b0);
      chk("abort_data", write_data, 16'h0000);
      chk("abort_addr", write_addr, 3'd0);
    end
    rst = 1'b1;
    runOp(16'd4, 16'd6, 16'd13, 3'd3, 1'b0);

    for (int k = 0; k < 30; k++) begin
      rn = 16'($urandom_range(1, 65535));
      ra = (k % 5 == 4) ? 16'($urandom_range(32'(rn), 65535)) : 16'($urandom_range(0, 32'(rn) - 1));
      rb = 16'($urandom);
      if (k % 7 == 6) rn = 16'h0000;
      runOp(ra, rb, rn, 3'($urandom), k % 4 == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modmul_unit.md
MODMUL_UNIT -- requirements
Module: modmul_unit

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-004 SHALL have port op_a  input  16  multiplicand, taken from register-file rs read data.
REQ-005 SHALL have port op_b  input  16  multiplier, taken from register-file rt read data.
REQ-006 SHALL have port modulus  input  16  modulus n, unsigned.
REQ-007 SHALL have port dest_addr  input  3  register-file write-back address.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (CALC or WB).
REQ-009 SHALL have port done  output  1  one-cycle completion pulse, success or error.
REQ-010 SHALL have port err  output  1  one-cycle pulse; operands rejected.
REQ-011 SHALL have port reg_write  output  1  register-file write enable.
REQ-012 SHALL have port write_addr  output  3  register-file write address.
REQ-013 SHALL have port write_data  output  16  result (op_a*op_b) mod modulus.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, WB, ERR.
REQ-015 IDLE with start=1 at edge k SHALL latch op_a, op_b, modulus and dest_addr into internal registers.
REQ-016 At that edge, if modulus==0 or op_a>=modulus, the FSM SHALL go to ERR; otherwise it SHALL go to CALC with accumulator R=0 and bit counter=15.
REQ-017 Each CALC edge SHALL process latched b[cnt], MSB first.
REQ-018 The CALC step SHALL be: T=2R, and if T>=n then T=T-n.
REQ-019 Then, if b[cnt]=1: T=T+a, and if T>=n then T=T-n; R<=T.
REQ-020 Intermediate sums SHALL be computed at 17 bits so that 2R and R+a never overflow; R SHALL always stay < n.
REQ-021 CALC SHALL decrement cnt each edge; the edge that processes cnt==0 SHALL move to WB, so CALC lasts exactly 16 cycles (edges k+1..k+16).
REQ-022 In WB (cycle after edge k+16), the block SHALL assert reg_write=1 and done=1, with write_data=R and write_addr=latched dest_addr.
REQ-023 WB SHALL return to IDLE at the next edge; reg_write SHALL be high for exactly one cycle per successful operation.
REQ-024 ERR SHALL assert err=1 and done=1 for one cycle, keep reg_write=0, and return to IDLE.
REQ-025 busy SHALL be high in CALC and WB and low in IDLE and ERR.
REQ-026 start SHALL be ignored in CALC, WB and ERR; input changes after the latch edge SHALL NOT affect the result.
REQ-027 start sampled high in the IDLE cycle directly after WB or ERR SHALL be accepted (back-to-back operation).
REQ-028 Outside WB, reg_write SHALL be 0, while write_data and write_addr hold their last values.
REQ-029 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 rst=0 at a rising edge SHALL force state IDLE; R, counter, latched operands, write_data and write_addr SHALL be 0.
REQ-031 While in reset, busy, done, err and reg_write SHALL all be 0.
REQ-032 Reset asserted mid-CALC or in WB SHALL abort the operation with no reg_write pulse, and the block SHALL accept a new start in the first cycle after rst returns to 1.

Verification
REQ-033 Scenario: a=3, b=5, n=7, dest=2, start at edge k -> busy from k+1; reg_write=1, write_data=0x0001, write_addr=2 in the cycle after edge k+16 only.
REQ-034 Scenario: a=0xFFFE, b=0xFFFE, n=0xFFFF -> write_data=0x0001, with no 17-bit overflow corruption.
REQ-035 Scenario: n=0 -> err=1 and done=1 for one cycle, reg_write never asserted, busy stays 0. Repeat with a=9, n=7 and expect the same response.
REQ-036 Scenario: b=0x0000, a=5, n=11 -> write_data=0x0000. Also a=0, n=1 -> write_data=0x0000.
REQ-037 Scenario: start pulsed with new operands at edge k+5 -> ignored; the result is still that of the operands latched at k.
REQ-038 Scenario: rst=0 at edge k+8 -> all outputs 0 and no reg_write. A start after reset with a=4, b=6, n=13 -> write_data=0x000B.
